fadd_ctrl: RTL and testbench
============================

FADD_CTRL -- requirements
Module: fadd_ctrl

Interface
REQ-001 Parameter DEPTH, default 2: result FIFO depth in entries (1..4).
REQ-002 Parameter TIMEOUT, default 31: max cycles in RUN before abort (1..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operand pair this cycle.
REQ-007 in_a, in_b  input  32 each  IEEE-754 single operands.
REQ-008 out_valid  output  1  FIFO head holds a result.
REQ-009 out_ready  input  1  consumer pops head this cycle.
REQ-010 out_result  output  32  FIFO head result word.
REQ-011 out_flags  output  3  FIFO head {over, under, zero}.
REQ-012 add_start  output  1  level enable to adder core Start_Sig.
REQ-013 add_a, add_b  output  32 each  operands to adder core A, B.
REQ-014 add_result  input  32  adder core Result.
REQ-015 add_done  input  4  adder core Done_Sig {over, under, zero, done}.
REQ-016 busy  output  1  high in RUN or DRAIN.
REQ-017 err  output  1  sticky timeout error.

Function
REQ-018 States IDLE, RUN, DRAIN; single operation in flight.
REQ-019 in_ready = (state==IDLE) && fifo_count<DEPTH && !err, combinational.
REQ-020 Accept (in_valid && in_ready at edge): latch in_a/in_b into add_a/add_b, add_start<=1, clear timeout counter, IDLE->RUN.
REQ-021 add_a/add_b held stable from accept until next accept; never change while add_start high.
REQ-022 RUN: timeout counter increments each cycle; add_done[0] sampled high -> push {add_result, add_done[3:1]} into FIFO, RUN->DRAIN, add_start stays 1.
REQ-023 DRAIN: exactly one cycle, add_start<=0, DRAIN->IDLE, so the adder core sequencer returns to its idle step before Start_Sig drops.
REQ-024 RUN with counter==TIMEOUT and add_done[0] low: no push, err<=1, add_start<=0, RUN->IDLE.
REQ-025 err sticky until reset; while err=1 in_ready=0; FIFO still drains.
REQ-026 FIFO: DEPTH entries, circular read/write pointers wrap at DEPTH, count 0..DEPTH.
REQ-027 out_valid = count!=0; out_result/out_flags = head entry, stable while out_valid && !out_ready.
REQ-028 Pop when out_valid && out_ready; pop on empty ignored.
REQ-029 Simultaneous push and pop: both performed, count unchanged; push into empty FIFO visible as out_valid next cycle.
REQ-030 Push never occurs with FIFO full (guaranteed by REQ-019 check at accept).
REQ-031 With adder core attached: out_valid rises 10 cycles after accept edge; in_ready high again 11 cycles after accept; throughput one result per 12 cycles when back-to-back.
REQ-032 add_done[0] outside RUN ignored.

Reset
REQ-033 rst_n low, any time including mid-RUN: state=IDLE, add_start=0, add_a=add_b=0, FIFO pointers and count=0, out_valid=0, out_result=0, out_flags=0, timeout counter=0, err=0, busy=0.
REQ-034 First accept possible on first edge after rst_n deasserts.

Verification
REQ-035 Accept A=0x3F800000, B=0x40000000 with out_ready=1 -> out_valid after 10 cycles, out_result=0x40400000, one-cycle pulse.
REQ-036 out_ready=0, three back-to-back ops (DEPTH=2) -> two results buffered, in_ready=0 after second push, third accepted only after one pop.
REQ-037 Pop and push in same edge with count=1 -> count stays 1, head advances to new entry in order.
REQ-038 Stub adder never asserts done -> err=1 after TIMEOUT+1 cycles in RUN, add_start=0, no push, in_ready stays 0.
REQ-039 rst_n pulsed low 4 cycles into RUN -> all outputs at REQ-033 values immediately; next op completes normally.
REQ-040 add_start checked high continuously from accept through DRAIN, low afterwards; add_a/add_b unchanged throughout.

Source files
------------

// File: rtl/fadd_ctrl.sv
// Handshake controller for a multi-cycle IEEE-754 single-precision adder core.
// Sequences one operation at a time, buffers results in a small FIFO and flags timeouts.
module fadd_ctrl #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags,
    output logic        add_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_result,
    input  logic [3:0]  add_done,
    output logic        busy,
    output logic        err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
    localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stateType;

    stateType         state;
    stateType         stateNext;
    logic             addStartNext;
    logic             accept;
    logic             push;
    logic             pop;
    logic             abort;
    logic [7:0]       toutCnt;
    logic [CNT_W-1:0] fifoCount;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [31:0]      resultMem [DEPTH];
    logic [2:0]       flagsMem  [DEPTH];

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign in_ready  = (state == IDLE) && (fifoCount < DEPTH_CNT) && !err;
    assign accept    = in_valid && in_ready;
    assign out_valid = (fifoCount != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);

    // NOTE: next-state logic is purely combinational, so every output gets a
    // default before the case statement; a missing default would infer a latch.
    always_comb begin
        stateNext    = state;
        addStartNext = add_start;
        push         = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext    = RUN;
                    addStartNext = 1'b1;
                end
            end
            RUN: begin
                if (add_done[0]) begin
                    push      = 1'b1;
                    stateNext = DRAIN;
                end else if (toutCnt == TIMEOUT_CNT) begin
                    abort        = 1'b1;
                    addStartNext = 1'b0;
                    stateNext    = IDLE;
                end
            end
            DRAIN: begin
                // Start drops one cycle after done so the core's sequencer is idle first.
                addStartNext = 1'b0;
                stateNext    = IDLE;
            end
            default: begin
                addStartNext = 1'b0;
                stateNext    = IDLE;
            end
        endcase
    end

    // NOTE: all sequential state below uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            add_start <= 1'b0;
        end else begin
            state     <= stateNext;
            add_start <= addStartNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a <= '0;
            add_b <= '0;
        end else if (accept) begin
            add_a <= in_a;
            add_b <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toutCnt <= '0;
        end else if (accept) begin
            toutCnt <= '0;
        end else if (state == RUN && !push && !abort) begin
            toutCnt <= toutCnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (abort) begin
            err <= 1'b1;
        end
    end

    // NOTE: the storage array is reset because the head entry drives the
    // outputs directly and must read as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                resultMem[i] <= '0;
                flagsMem[i]  <= '0;
            end
        end else if (push) begin
            resultMem[wrPtr] <= add_result;
            flagsMem[wrPtr]  <= add_done[3:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    assign out_result = resultMem[rdPtr];
    assign out_flags  = flagsMem[rdPtr];

endmodule

// File: tb/tb_fadd_ctrl.sv
// Directed bench for fadd_ctrl with a stub adder core (done 10 cycles after start)
// and a result scoreboard checked whenever the FIFO head is popped.
module tb_fadd_ctrl;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_result;
    logic [3:0]  add_done;
    logic        busy;
    logic        err;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
    } expType;

    expType sb[$];
    int     checks   = 0;
    int     failures = 0;

    // Stub adder core: done (with flags) from the 10th cycle of Start_Sig onward.
    logic [4:0]  stubCnt;
    logic        stubEnable;
    logic        stubDone;
    logic [34:0] stubOut;

    fadd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .add_done   (add_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] stubSum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return {3'b000, 32'h40400000};
            {32'h3F000000, 32'h3E800000}: return {3'b000, 32'h3F400000};
            {32'h40400000, 32'hC0400000}: return {3'b001, 32'h00000000};
            {32'h7F7FFFFF, 32'h7F7FFFFF}: return {3'b100, 32'h7F800000};
            {32'h3FC00000, 32'h40200000}: return {3'b000, 32'h40800000};
            {32'h00800000, 32'h80400000}: return {3'b010, 32'h00400000};
            default:                      return {3'b000, 32'hDEADBEEF};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!add_start) stubCnt <= 5'd0;
        else if (stubCnt != 5'd31) stubCnt <= stubCnt + 5'd1;
    end

    always_comb begin
        stubOut    = stubSum(add_a, add_b);
        stubDone   = add_start && stubEnable && (stubCnt >= 5'd9);
        add_done   = stubDone ? {stubOut[34:32], 1'b1} : 4'b0000;
        add_result = stubDone ? stubOut[31:0] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pop of the FIFO head is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("pop_without_expectation", 32'(out_valid), 32'd0);
            end else begin
                expType e;
                e = sb.pop_front();
                check("out_result", out_result, e.res);
                check("out_flags", 32'(out_flags), 32'(e.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic acceptOp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                            input logic [2:0] f, input bit pushExp, output int waited);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        while (waited < 200) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
        end
        if (waited >= 200) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (pushExp) sb.push_back('{res: r, flags: f});
    endtask

    // One operation with out_ready high, checking latency and start/operand stability.
    task automatic timedOp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                           input logic [2:0] f);
        int   waited;
        int   lat;
        bit   startOk;
        bit   opsOk;
        logic ir10, ir11, ov11;
        acceptOp(a, b, r, f, 1'b1, waited);
        check("accept_first_edge", 32'(waited), 32'd0);
        lat = -1; startOk = 1'b1; opsOk = 1'b1;
        ir10 = 1'bx; ir11 = 1'bx; ov11 = 1'bx;
        for (int n = 0; n <= 14; n++) begin
            @(negedge clk);
            if (n <= 10 && add_start !== 1'b1) startOk = 1'b0;
            if (n >= 11 && add_start !== 1'b0) startOk = 1'b0;
            if (add_a !== a || add_b !== b) opsOk = 1'b0;
            if (lat < 0 && out_valid === 1'b1) lat = n;
            if (n == 10) ir10 = in_ready;
            if (n == 11) begin
                ir11 = in_ready;
                ov11 = out_valid;
            end
        end
        check("out_valid_latency", 32'(lat), 32'd10);
        check("add_start_window", 32'(startOk), 32'd1);
        check("operands_stable", 32'(opsOk), 32'd1);
        check("in_ready_in_drain", 32'(ir10), 32'd0);
        check("in_ready_rearm", 32'(ir11), 32'd1);
        check("out_valid_pulse", 32'(ov11), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   w;
        int   errAt;
        bit   blocked;
        logic s31, s32, b32, ir32, ov32;
        logic [2:0] f32;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1; stubEnable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_add_start", 32'(add_start), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1.0 + 2.0 right after reset release
        rst_n = 1'b1;
        timedOp(32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);

        // Consumer stalled: two results fill the FIFO, the third waits for a pop
        out_ready = 1'b0;
        acceptOp(32'h3F000000, 32'h3E800000, 32'h3F400000, 3'b000, 1'b1, w);
        check("fill_first_accept", 32'(w), 32'd0);
        acceptOp(32'h40400000, 32'hC0400000, 32'h00000000, 3'b001, 1'b1, w);
        check("rearm_gap", 32'(w), 32'd11);
        repeat (12) @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        check("full_head_result", out_result, 32'h3F400000);
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_a = 32'h7F7FFFFF; in_b = 32'h7F7FFFFF;
        blocked = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || add_start !== 1'b0) blocked = 1'b0;
        end
        check("full_blocks_accept", 32'(blocked), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        acceptOp(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b100, 1'b1, w);
        check("accept_after_pop", 32'(w), 32'd0);

        // Pop of the zero result lands on the same edge as the overflow push
        repeat (9) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("pushpop_before", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("pushpop_count_kept", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("pushpop_then_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Timeout with one result still buffered
        out_ready = 1'b0;
        acceptOp(32'h00800000, 32'h80400000, 32'h00400000, 3'b010, 1'b1, w);
        repeat (11) @(posedge clk);
        #1;
        stubEnable = 1'b0;
        acceptOp(32'h3F800000, 32'h40000000, 32'h0, 3'b000, 1'b0, w);
        errAt = -1;
        s31 = 1'bx; s32 = 1'bx; b32 = 1'bx; ir32 = 1'bx; ov32 = 1'bx; f32 = 3'bxxx;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (errAt < 0 && err === 1'b1) errAt = n;
            if (n == 31) s31 = add_start;
            if (n == 32) begin
                s32 = add_start; b32 = busy; ir32 = in_ready; ov32 = out_valid; f32 = out_flags;
            end
        end
        check("timeout_cycle", 32'(errAt), 32'(TIMEOUT + 1));
        check("timeout_start_before", 32'(s31), 32'd1);
        check("timeout_start_after", 32'(s32), 32'd0);
        check("timeout_busy", 32'(b32), 32'd0);
        check("timeout_in_ready", 32'(ir32), 32'd0);
        check("timeout_no_push_valid", 32'(ov32), 32'd1);
        check("timeout_head_flags", 32'(f32), 32'b010);
        @(posedge clk);
        #1;
        stubEnable = 1'b1;
        in_valid = 1'b1; in_a = 32'h3F000000; in_b = 32'h3E800000;
        blocked = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || add_start !== 1'b0) blocked = 1'b0;
        end
        check("err_blocks_accept", 32'(blocked), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("err_fifo_drained", 32'(out_valid), 32'd0);
        check("err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1;

        // Reset clears err; then a reset mid-RUN with a buffered result
        rst_n = 1'b0;
        #1;
        check("reset_clears_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        acceptOp(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 3'b000, 1'b0, w);
        check("accept_after_err_reset", 32'(w), 32'd0);
        repeat (12) @(negedge clk);
        check("buffered_flags", 32'(out_flags), 32'b100);
        @(posedge clk);
        #1;
        acceptOp(32'h3F000000, 32'h3E800000, 32'h0, 3'b000, 1'b0, w);
        repeat (4) @(posedge clk);
        #1;
        check("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_start", 32'(add_start), 32'd0);
        check("midrun_rst_add_a", add_a, 32'd0);
        check("midrun_rst_add_b", add_b, 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_result", out_result, 32'd0);
        check("midrun_rst_flags", 32'(out_flags), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        timedOp(32'h3FC00000, 32'h40200000, 32'h40800000, 3'b000);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
